// File: rtl/vga_pkg.sv
// Shared types and defaults for the video memory scheduler.
package vga_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DIM_W  = 11;
    localparam int unsigned PW_W   = 3;

    localparam int unsigned FIFO_DEPTH_DEF   = 16;
    localparam int unsigned URGENT_LEVEL_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_SCAN = 2'd2
    } grant_t;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/scan_fifo.sv
// Synchronous first-word-fall-through FIFO holding scanout words.
module scan_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/video_mem_scheduler.sv
// Shares one memory port between frame scanout prefetch and CPU accesses.
module video_mem_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int unsigned URGENT_LEVEL = URGENT_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [DIM_W-1:0]  screen_width,
    input  logic [DIM_W-1:0]  screen_height,
    input  logic [PW_W-1:0]   pixel_width,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_empty,
    output logic              underflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_grant,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LW    = CW + 1;
    localparam int unsigned REP_W = 8;

    sched_state_t      state;
    sched_state_t      state_nxt;
    grant_t            grant;
    mem_cmd_t          cmd_c;

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] line_start;
    logic [DIM_W-1:0]  word_cnt;
    logic [DIM_W-1:0]  line_cnt;
    logic [REP_W-1:0]  rep_cnt;

    logic [DIM_W-1:0]  words_per_line;
    logic [DIM_W-1:0]  unique_lines;
    logic [REP_W-1:0]  rep_last;
    logic              frame_empty;
    logic              line_end;
    logic              rep_end;
    logic              last_word;

    logic              scan_inflight;
    logic              cpu_rd_inflight;
    logic              underflow_q;

    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_push;
    logic [LW-1:0]     level;

    logic              scan_ok;
    logic              urgent;
    logic              scan_gnt;
    logic              cpu_gnt;

    // Frame geometry derived from the replication factor.
    assign words_per_line = screen_width >> pixel_width;
    assign unique_lines   = screen_height >> pixel_width;
    assign rep_last       = REP_W'((REP_W'(1) << pixel_width) - REP_W'(1));
    assign frame_empty    = (words_per_line == '0) || (unique_lines == '0);
    assign line_end       = (word_cnt == words_per_line - DIM_W'(1));
    assign rep_end        = (rep_cnt == rep_last);
    assign last_word      = line_end && rep_end && (line_cnt == unique_lines - DIM_W'(1));

    // Words buffered plus the scanout read whose data has not yet returned.
    assign level = LW'(fifo_count) + LW'(scan_inflight);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration and next-state; reset suppresses every grant.
    always_comb begin
        state_nxt = state;
        grant     = GNT_NONE;
        scan_ok   = 1'b0;
        urgent    = 1'b0;

        scan_ok = (state == ST_FETCH) && !frame_start && !frame_empty;
        urgent  = scan_ok && (level < LW'(URGENT_LEVEL));

        if (reset) begin
            grant = GNT_NONE;
        end else if (urgent) begin
            grant = GNT_SCAN;
        end else if (cpu_req) begin
            grant = GNT_CPU;
        end else if (scan_ok && (level < LW'(FIFO_DEPTH))) begin
            grant = GNT_SCAN;
        end

        case (state)
            ST_FETCH: begin
                if (frame_empty || ((grant == GNT_SCAN) && last_word)) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = state;
        endcase

        if (frame_start) begin
            state_nxt = ST_FETCH;
        end
    end

    assign scan_gnt = (grant == GNT_SCAN);
    assign cpu_gnt  = (grant == GNT_CPU);

    // Memory command mux.
    always_comb begin
        cmd_c    = '0;
        cmd_c.en = scan_gnt || cpu_gnt;
        if (cpu_gnt) begin
            cmd_c.we    = cpu_we;
            cmd_c.addr  = cpu_addr;
            cmd_c.wdata = cpu_we ? cpu_wdata : '0;
        end else if (scan_gnt) begin
            cmd_c.addr = fetch_addr;
        end
    end

    assign mem_en    = cmd_c.en;
    assign mem_we    = cmd_c.we;
    assign mem_addr  = cmd_c.addr;
    assign mem_wdata = cmd_c.wdata;
    assign cpu_grant = cpu_gnt;

    // Fetch address walk: repeat each line, then advance; 16-bit wrap is natural.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr <= '0;
            line_start <= '0;
            word_cnt   <= '0;
            line_cnt   <= '0;
            rep_cnt    <= '0;
        end else if (frame_start) begin
            fetch_addr <= fb_base;
            line_start <= fb_base;
            word_cnt   <= '0;
            line_cnt   <= '0;
            rep_cnt    <= '0;
        end else if (scan_gnt) begin
            if (line_end) begin
                word_cnt <= '0;
                if (rep_end) begin
                    rep_cnt    <= '0;
                    line_cnt   <= line_cnt + DIM_W'(1);
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                    line_start <= fetch_addr + ADDR_W'(1);
                end else begin
                    rep_cnt    <= rep_cnt + REP_W'(1);
                    fetch_addr <= line_start;
                end
            end else begin
                word_cnt   <= word_cnt + DIM_W'(1);
                fetch_addr <= fetch_addr + ADDR_W'(1);
            end
        end
    end

    // Read-return tracking and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_inflight   <= 1'b0;
            cpu_rd_inflight <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            scan_inflight   <= scan_gnt;
            cpu_rd_inflight <= cpu_gnt && !cpu_we;
            if (frame_start) begin
                underflow_q <= 1'b0;
            end else if (pix_pop && fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // A scanout word returning in a frame_start cycle belongs to the old frame.
    assign fifo_push = scan_inflight && !frame_start;

    scan_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_scan_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (pix_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pix_data   = fifo_empty ? '0 : fifo_head;
    assign pix_empty  = fifo_empty;
    assign underflow  = underflow_q;
    assign cpu_rvalid = cpu_rd_inflight && !reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_video_mem_scheduler.sv
// Directed bench for video_mem_scheduler; memory returns its own address as data.
module tb_video_mem_scheduler;
    import vga_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] fb_base;
    logic [10:0] screen_width;
    logic [10:0] screen_height;
    logic [2:0]  pixel_width;
    logic        frame_start;
    logic        pix_pop;
    logic [15:0] pix_data;
    logic        pix_empty;
    logic        underflow;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_grant;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] scan_log[$];
    logic [15:0] popped[$];

    video_mem_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .fb_base       (fb_base),
        .screen_width  (screen_width),
        .screen_height (screen_height),
        .pixel_width   (pixel_width),
        .frame_start   (frame_start),
        .pix_pop       (pix_pop),
        .pix_data      (pix_data),
        .pix_empty     (pix_empty),
        .underflow     (underflow),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_grant     (cpu_grant),
        .cpu_rdata     (cpu_rdata),
        .cpu_rvalid    (cpu_rvalid),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model (read data = address, one cycle latency) and scanout address log.
    always @(posedge clk) begin
        mem_rdata <= (mem_en && !mem_we) ? mem_addr : 16'hDEAD;
        if (mem_en && !mem_we && !cpu_grant) scan_log.push_back(mem_addr);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop whenever a word is available, recording it, until n words or budget cycles.
    task automatic drain(input int n, input int budget);
        popped.delete();
        pix_pop = 1'b0;
        for (int c = 0; c < budget && popped.size() < n; c++) begin
            tick();
            if (!pix_empty) begin
                popped.push_back(pix_data);
                pix_pop = 1'b1;
            end else begin
                pix_pop = 1'b0;
            end
        end
        tick();
        pix_pop = 1'b0;
    endtask

    task automatic start_frame(input logic [15:0] base, input logic [10:0] w,
                               input logic [10:0] h, input logic [2:0] pw);
        tick();
        fb_base = base; screen_width = w; screen_height = h; pixel_width = pw;
        scan_log.delete();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fb_base = '0; screen_width = '0; screen_height = '0; pixel_width = '0;
        frame_start = 1'b0; pix_pop = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (3) tick();
        n_checks++; if (pix_empty !== 1'b1) begin n_fail++; $display("FAIL reset_pix_empty: got %b expected 1", pix_empty); end
        n_checks++; if (pix_data !== 16'h0) begin n_fail++; $display("FAIL reset_pix_data: got %h expected 0000", pix_data); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        n_checks++; if (cpu_grant !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_grant: got %b expected 0", cpu_grant); end
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rvalid: got %b expected 0", cpu_rvalid); end
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem: got en=%b we=%b expected 0 0", mem_en, mem_we); end
        n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); end
        reset = 1'b0;
        tick();
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL idle_mem_en: got %b expected 0", mem_en); end
    endtask

    task automatic test_basic_frame();
        start_frame(16'h1000, 11'd8, 11'd2, 3'd0);
        drain(16, 200);
        n_checks++; if (popped.size() != 16) begin n_fail++; $display("FAIL basic_count: got %0d words expected 16", popped.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (popped[i] !== 16'h1000 + 16'(i)) begin n_fail++; $display("FAIL basic_word[%0d]: got %h expected %h", i, popped[i], 16'h1000 + 16'(i)); end
        end
        n_checks++; if (scan_log.size() != 16) begin n_fail++; $display("FAIL basic_reads: got %0d reads expected 16", scan_log.size()); end
        n_checks++; if (dut.state !== ST_DONE) begin n_fail++; $display("FAIL basic_done: got %0d expected %0d", dut.state, ST_DONE); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL basic_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_line_repeat();
        logic [15:0] exp;
        start_frame(16'h1000, 11'd8, 11'd4, 3'd1);
        drain(16, 200);
        repeat (4) tick();
        n_checks++; if (scan_log.size() != 16) begin n_fail++; $display("FAIL repeat_reads: got %0d reads expected 16", scan_log.size()); end
        for (int i = 0; i < 16; i++) begin
            exp = 16'h1000 + 16'((i / 8) * 4 + (i % 4));
            n_checks++; if (scan_log[i] !== exp) begin n_fail++; $display("FAIL repeat_addr[%0d]: got %h expected %h", i, scan_log[i], exp); end
        end
        n_checks++; if (dut.state !== ST_DONE) begin n_fail++; $display("FAIL repeat_done: got %0d expected %0d", dut.state, ST_DONE); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr[4];
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
        start_frame(16'hFFFE, 11'd4, 11'd1, 3'd0);
        drain(4, 100);
        repeat (3) tick();
        n_checks++; if (scan_log.size() != 4) begin n_fail++; $display("FAIL wrap_reads: got %0d reads expected 4", scan_log.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (scan_log[i] !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, scan_log[i], exp_addr[i]); end
            n_checks++; if (popped[i] !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_word[%0d]: got %h expected %h", i, popped[i], exp_addr[i]); end
        end
    endtask

    task automatic test_zero_dims();
        // 4 lines >> 3 leaves no unique lines.
        start_frame(16'h1000, 11'd8, 11'd4, 3'd3);
        n_checks++; if (dut.state !== ST_FETCH || mem_en !== 1'b0) begin n_fail++; $display("FAIL zero_fetch: got state=%0d en=%b expected %0d 0", dut.state, mem_en, ST_FETCH); end
        tick();
        n_checks++; if (dut.state !== ST_DONE) begin n_fail++; $display("FAIL zero_done: got %0d expected %0d", dut.state, ST_DONE); end
        repeat (3) tick();
        n_checks++; if (scan_log.size() != 0) begin n_fail++; $display("FAIL zero_reads: got %0d reads expected 0", scan_log.size()); end
    endtask

    task automatic test_cpu_priority();
        start_frame(16'h2000, 11'd64, 11'd4, 3'd0);
        repeat (30) tick();
        n_checks++; if (pix_empty !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL full_idle: got empty=%b en=%b expected 0 0", pix_empty, mem_en); end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'hBEEF;
        #1;
        n_checks++; if (cpu_grant !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL cpu_write_grant: got grant=%b en=%b we=%b expected 1 1 1", cpu_grant, mem_en, mem_we); end
        n_checks++; if (mem_addr !== 16'h0005 || mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL cpu_write_bus: got %h<-%h expected 0005<-beef", mem_addr, mem_wdata); end
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0040;
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid: got %b expected 0", cpu_rvalid); end
        // Level falls 16,15,...,4 while the CPU keeps winning.
        for (int k = 0; k < 13; k++) begin
            pix_pop = 1'b1;
            #1;
            n_checks++; if (cpu_grant !== 1'b1) begin n_fail++; $display("FAIL cpu_wins[%0d]: got %b expected 1", k, cpu_grant); end
            tick();
        end
        // Level 3: urgent scanout preempts the held CPU request.
        pix_pop = 1'b0;
        #1;
        n_checks++; if (cpu_grant !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL urgent_scan: got grant=%b en=%b we=%b expected 0 1 0", cpu_grant, mem_en, mem_we); end
        n_checks++; if (mem_addr !== 16'h2010) begin n_fail++; $display("FAIL urgent_addr: got %h expected 2010", mem_addr); end
        n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h0040) begin n_fail++; $display("FAIL cpu_read_data: got v=%b d=%h expected 1 0040", cpu_rvalid, cpu_rdata); end
        tick();
        n_checks++; if (cpu_grant !== 1'b1) begin n_fail++; $display("FAIL cpu_resumes: got %b expected 1", cpu_grant); end
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_after_scan: got %b expected 0", cpu_rvalid); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_underflow_flush();
        start_frame(16'h3000, 11'd16, 11'd1, 3'd0);
        pix_pop = 1'b1;
        #1;
        n_checks++; if (pix_empty !== 1'b1 || pix_data !== 16'h0) begin n_fail++; $display("FAIL empty_pop: got empty=%b data=%h expected 1 0000", pix_empty, pix_data); end
        tick();
        pix_pop = 1'b0;
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b expected 1", underflow); end
        repeat (4) tick();
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b expected 1", underflow); end
        n_checks++; if (pix_empty !== 1'b0) begin n_fail++; $display("FAIL refill: got empty=%b expected 0", pix_empty); end
        // Restart while a scanout read is outstanding.
        fb_base = 16'h4000; screen_width = 11'd64; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        #1;
        n_checks++; if (pix_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b expected 1", pix_empty); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b expected 0", underflow); end
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h4000) begin n_fail++; $display("FAIL restart_addr: got en=%b addr=%h expected 1 4000", mem_en, mem_addr); end
        tick();
        n_checks++; if (pix_empty !== 1'b1) begin n_fail++; $display("FAIL stale_dropped: got empty=%b expected 1", pix_empty); end
        tick();
        n_checks++; if (pix_empty !== 1'b0 || pix_data !== 16'h4000) begin n_fail++; $display("FAIL new_head: got empty=%b data=%h expected 0 4000", pix_empty, pix_data); end
    endtask

    task automatic test_reset_midfetch();
        repeat (25) tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0077;
        #1;
        n_checks++; if (cpu_grant !== 1'b1) begin n_fail++; $display("FAIL pre_reset_grant: got %b expected 1", cpu_grant); end
        tick();
        cpu_req = 1'b0; reset = 1'b1;
        #1;
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_in_reset: got %b expected 0", cpu_rvalid); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d expected %0d", dut.state, ST_IDLE); end
        n_checks++; if (pix_empty !== 1'b1 || pix_data !== 16'h0) begin n_fail++; $display("FAIL midreset_fifo: got empty=%b data=%h expected 1 0000", pix_empty, pix_data); end
        n_checks++; if (underflow !== 1'b0 || cpu_grant !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got uf=%b grant=%b expected 0 0", underflow, cpu_grant); end
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_rvalid: got %b expected 0", cpu_rvalid); end
        n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL midreset_mem: got en=%b we=%b expected 0 0", mem_en, mem_we); end
        tick();
        n_checks++; if (cpu_rvalid !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_quiet: got v=%b en=%b expected 0 0", cpu_rvalid, mem_en); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_line_repeat();
        test_wrap();
        test_zero_dims();
        test_cpu_priority();
        test_underflow_flush();
        test_reset_midfetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_mem_scheduler.md
VIDEO_MEM_SCHEDULER -- requirements
Module: video_mem_scheduler

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 16, scanout buffer entries (power of 2); URGENT_LEVEL, default 4, occupancy below which scanout preempts CPU.
REQ-002 SHALL have ports: clk  in  1  single clock for all logic; reset  in  1  synchronous, active-high.
REQ-003 SHALL have config ports: fb_base  in  16  frame base word address; screen_width  in  11  active pixels per line; screen_height  in  11  active lines; pixel_width  in  3  log2 pixel/line replication (0..3).
REQ-004 SHALL have frame_start  in  1  one-cycle pulse that starts a new frame fetch.
REQ-005 SHALL have scanout ports: pix_pop  in  1  consume one word; pix_data  out  16  head word; pix_empty  out  1; underflow  out  1  sticky.
REQ-006 SHALL have CPU ports: cpu_req  in  1; cpu_we  in  1; cpu_addr  in  16; cpu_wdata  in  16; cpu_grant  out  1  access accepted this cycle; cpu_rdata  out  16; cpu_rvalid  out  1.
REQ-007 SHALL have memory ports: mem_en  out  1; mem_we  out  1; mem_addr  out  16; mem_wdata  out  16; mem_rdata  in  16 (valid exactly 1 cycle after a read mem_en).

Function
REQ-008 SHALL issue at most one memory access per cycle; mem_en=grant of CPU or scanout.
REQ-009 SHALL use states IDLE, FETCH, DONE; IDLE->FETCH and any->FETCH on frame_start; FETCH->DONE after the last word of the frame is issued; DONE holds until frame_start.
REQ-010 SHALL compute words_per_line = screen_width >> pixel_width and unique_lines = screen_height >> pixel_width; each unique line SHALL be fetched (1 << pixel_width) times from the same addresses.
REQ-011 SHALL fetch sequentially from fb_base; after the last word of a line, address rewinds to line start unless the repeat count is reached, then advances to the next line; addresses wrap modulo 2^16.
REQ-012 SHALL define level = FIFO count + in-flight scanout reads; scanout is urgent when in FETCH and level < URGENT_LEVEL.
REQ-013 SHALL arbitrate in priority order: urgent scanout; cpu_req; scanout when in FETCH and level < FIFO_DEPTH; else idle.
REQ-014 SHALL assert cpu_grant combinationally in the cycle the CPU access drives the memory port; CPU holds request signals until granted.
REQ-015 SHALL assert cpu_rvalid with cpu_rdata=mem_rdata one cycle after a granted CPU read; never for writes.
REQ-016 SHALL push mem_rdata into the FIFO one cycle after a scanout read; FIFO never overflows by construction of REQ-013.
REQ-017 SHALL present the FIFO head on pix_data (first-word fall-through); pix_pop while non-empty removes it; push and pop in the same cycle keep count constant.
REQ-018 SHALL, on pix_pop while empty, leave the FIFO unchanged, drive pix_data=0, set underflow.
REQ-019 SHALL, on frame_start, flush the FIFO, reset address/line/repeat counters, clear underflow, and discard a scanout read in flight; a CPU read in flight SHALL still complete.
REQ-020 SHALL, with words_per_line=0 or unique_lines=0, go directly FETCH->DONE without memory access.

Reset
REQ-021 SHALL on reset: state IDLE, FIFO empty, pix_empty=1, pix_data=0, underflow=0, cpu_grant=0, cpu_rvalid=0, mem_en=0, mem_we=0, counters 0.
REQ-022 SHALL treat reset as dominant over frame_start and all requests in the same cycle; in-flight reads SHALL be discarded.

Structure
REQ-023 SHALL take FIFO_DEPTH/URGENT_LEVEL defaults and state encoding from shared package vga_pkg.
REQ-024 SHALL instantiate one sub-module, scan_fifo (synchronous FWFT FIFO with count output).

Verification
REQ-025 SHALL cover: fb_base=0x1000, width=8, height=2, pixel_width=0, frame_start, pop continuously -> words 0x1000..0x100F read in order, then DONE, no underflow.
REQ-026 SHALL cover: pixel_width=1, width=8, height=4 -> addresses 0x1000..3, 0x1000..3, 0x1004..7, 0x1004..7.
REQ-027 SHALL cover: FIFO full, cpu_req write 0x0005<-0xBEEF -> grant same cycle, mem_we=1; then level<4 with cpu_req held -> scanout wins until level>=4.
REQ-028 SHALL cover: fb_base=0xFFFE, 4 words -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-029 SHALL cover: pop on empty -> pix_data=0, underflow=1 until next frame_start; frame_start mid-frame with scanout read in flight -> FIFO empty next cycle, stale word not pushed.
REQ-030 SHALL cover: reset asserted mid-FETCH with CPU read in flight -> next cycle all outputs at reset values, cpu_rvalid stays 0.
